// File: rtl/ud_cnt.sv
// Up/down counter with parallel load. It either wraps or saturates at its limits.
// tc warns that the next enabled step hits a limit. ovf is a registered pulse
// raised on each step that wrapped or was clipped.
module ud_cnt #(
  parameter int               WIDTH    = 4,
  parameter int               SATURATE = 0,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] QMAX = '1;
  localparam logic [WIDTH-1:0] QMIN = '0;

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] q_nxt;
  logic             ovf_nxt;

  assign at_max = (q == QMAX);
  assign at_min = (q == QMIN);
  assign tc     = en & ((~ud & at_max) | (ud & at_min));

  // Load outranks counting, so a boundary step under load raises no ovf.
  always_comb begin
    q_nxt   = q;
    ovf_nxt = 1'b0;
    if (load) begin
      q_nxt = d;
    end else if (en) begin
      if (tc) begin
        ovf_nxt = 1'b1;
        if (SATURATE == 0) q_nxt = ud ? QMAX : QMIN;
      end else begin
        q_nxt = ud ? (q - WIDTH'(1)) : (q + WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q   <= INIT;
      ovf <= 1'b0;
    end else begin
      q   <= q_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_ud_cnt.sv
// Bench for ud_cnt with a wrapping and a saturating instance on shared inputs.
// It runs directed steps and then random steps, and checks both against an integer reference model.
module tb_ud_cnt;

  logic       clk = 1'b0;
  logic       rst_n, en, ud, load;
  logic [3:0] d;
  logic [3:0] q0, q1;
  logic       tc0, tc1, ovf0, ovf1;

  int vecs = 0;
  int errs = 0;
  int mq0 = 0, mq1 = 0;
  bit mo0 = 0, mo1 = 0;
  bit valid = 0;

  ud_cnt #(.WIDTH(4), .SATURATE(0), .INIT(4'd0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .ud(ud), .load(load), .d(d),
    .q(q0), .tc(tc0), .ovf(ovf0)
  );

  ud_cnt #(.WIDTH(4), .SATURATE(1), .INIT(4'd0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .ud(ud), .load(load), .d(d),
    .q(q1), .tc(tc1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_tc(input int q);
    return en && ((!ud && q == 15) || (ud && q == 0));
  endfunction

  // Reference: step in plain integers, then wrap the result into range or clip it.
  function automatic void upd(inout int q, inout bit o, input bit sat);
    int n;
    if (!rst_n) begin
      q = 0; o = 0;
    end else if (load) begin
      q = int'(d); o = 0;
    end else if (en) begin
      n = ud ? q - 1 : q + 1;
      if (n < 0 || n > 15) begin
        o = 1;
        n = sat ? q : (n + 16) % 16;
      end else begin
        o = 0;
      end
      q = n;
    end else begin
      o = 0;
    end
  endfunction

  task automatic step(input bit r, input bit e, input bit u, input bit l, input logic [3:0] dv);
    rst_n = r; en = e; ud = u; load = l; d = dv;
    #1;
    if (valid) begin
      chk("tc_wrap", 32'(tc0), 32'(exp_tc(mq0)));
      chk("tc_sat",  32'(tc1), 32'(exp_tc(mq1)));
    end
    @(posedge clk);
    #1;
    upd(mq0, mo0, 1'b0);
    upd(mq1, mo1, 1'b1);
    if (!r) valid = 1;
    if (valid) begin
      chk("q_wrap",   32'(q0),   32'(mq0));
      chk("ovf_wrap", 32'(ovf0), 32'(mo0));
      chk("q_sat",    32'(q1),   32'(mq1));
      chk("ovf_sat",  32'(ovf1), 32'(mo1));
    end
  endtask

  initial begin
    // reset, then count up 8
    step(0, 1, 0, 0, 4'd0);
    step(0, 1, 0, 0, 4'd0);
    chk("q_reset", 32'(q0), 32'd0);
    chk("ovf_reset", 32'(ovf0), 32'd0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 4'd0);
    chk("q_up8", 32'(q0), 32'd8);
    // down 5, up 3
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 4'd0);
    chk("q_down5", 32'(q0), 32'd3);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 4'd0);
    chk("q_up3", 32'(q0), 32'd6);
    // load 15 then up step over the top
    step(1, 0, 0, 1, 4'd15);
    step(1, 1, 0, 0, 4'd0);
    chk("q_upwrap", 32'(q0), 32'd0);
    chk("ovf_upwrap", 32'(ovf0), 32'd1);
    chk("q_upsat", 32'(q1), 32'd15);
    chk("ovf_upsat", 32'(ovf1), 32'd1);
    // from 0, down step under the bottom, then hold
    step(1, 0, 0, 1, 4'd0);
    step(1, 1, 1, 0, 4'd0);
    chk("q_dnwrap", 32'(q0), 32'd15);
    chk("ovf_dnwrap", 32'(ovf0), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 4'd0);
    chk("q_hold", 32'(q0), 32'd15);
    chk("ovf_hold", 32'(ovf0), 32'd0);
    // load on a boundary step wins and gives no ovf
    step(1, 1, 0, 1, 4'd4);
    chk("ovf_loadwin", 32'(ovf0), 32'd0);
    // reset beats load while counting
    step(1, 1, 0, 0, 4'd0);
    step(0, 1, 0, 1, 4'd9);
    chk("q_rst_over_load", 32'(q0), 32'd0);
    step(1, 1, 0, 1, 4'd9);
    chk("q_load9", 32'(q0), 32'd9);
    // randomized
    for (int i = 0; i < 1000; i++)
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 7) == 0), 4'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ud_cnt.md
UD_CNT -- requirements
Module: ud_cnt

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (legal 2..16).
REQ-002 Parameter: SATURATE, default 0; 0 = wrap at limits, 1 = hold at limits.
REQ-003 Parameter: INIT, default 0, reset value of q (WIDTH bits).
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-006 Port: rst_n  input  1  synchronous active-low reset.
REQ-007 Port: en  input  1  count enable, active-high.
REQ-008 Port: ud  input  1  direction; 0 = count up, 1 = count down.
REQ-009 Port: load  input  1  synchronous parallel load, active-high.
REQ-010 Port: d  input  WIDTH  parallel load value.
REQ-011 Port: q  output  WIDTH  registered counter value.
REQ-012 Port: tc  output  1  terminal count, combinational.
REQ-013 Port: ovf  output  1  registered one-cycle pulse, set when a count step wrapped or was clipped.

Function
REQ-014 All state updates occur on the rising edge of clk only; no latches, no asynchronous paths into q or ovf.
REQ-015 Per-edge priority: rst_n low > load high > en high > hold.
REQ-016 load=1 (rst_n high): q <= d on the same edge, regardless of en and ud; ovf <= 0.
REQ-017 en=1, load=0, ud=0: q <= q+1 modulo 2^WIDTH (SATURATE=0).
REQ-018 en=1, load=0, ud=1: q <= q-1 modulo 2^WIDTH (SATURATE=0).
REQ-019 en=0, load=0: q holds; ovf <= 0.
REQ-020 Latency: q reflects a count or load exactly one clock edge after the inputs are sampled.
REQ-021 Up-wrap boundary: q = 2^WIDTH-1, ud=0, en=1 -> q <= 0 and ovf <= 1 (SATURATE=0); q holds at 2^WIDTH-1 and ovf <= 1 (SATURATE=1).
REQ-022 Down-wrap boundary: q = 0, ud=1, en=1 -> q <= 2^WIDTH-1 and ovf <= 1 (SATURATE=0); q holds at 0 and ovf <= 1 (SATURATE=1).
REQ-023 ovf is high for exactly one cycle after a boundary step; it stays high on consecutive cycles only if boundary steps repeat.
REQ-024 tc = en & ((~ud & q == 2^WIDTH-1) | (ud & q == 0)); it flags that the next enabled step hits a boundary.
REQ-025 A change of ud takes effect on the next edge with no dead cycle; reversal at any value is legal.
REQ-026 Simultaneous load and boundary condition: load wins, no ovf.
REQ-027 All arithmetic is unsigned WIDTH-bit; no sign interpretation of q or d.

Reset
REQ-028 rst_n low at a rising edge: q <= INIT, ovf <= 0, overriding load and en.
REQ-029 Reset asserted mid-count takes effect on that edge; counting resumes on the first edge with rst_n high, from INIT.
REQ-030 q and ovf are undefined only before the first reset edge; after reset they are always defined.

Verification
REQ-031 rst_n=0 for 2 edges, then en=1, ud=0 for 8 edges -> q steps 0,1,...,8; tc=0; ovf=0.
REQ-032 From q=8, ud=1 for 5 edges, then ud=0 for 3 edges -> q = 7,6,5,4,3, then 4,5,6.
REQ-033 load=1, d=15, then en=1, ud=0 for 1 edge -> tc=1 before the edge; q=0 and ovf=1 for one cycle after; SATURATE=1 gives q=15 and ovf=1.
REQ-034 From q=0, ud=1, en=1 for 1 edge -> q=15 and ovf=1; en=0 for 3 edges -> q holds at 15 and ovf=0.
REQ-035 rst_n=0 and load=1, d=9 on the same edge while counting -> q=INIT (0); next edge with rst_n=1, load=1 -> q=9.
REQ-036 Randomized en, ud, load over 1000 cycles against a modulo-16 reference model -> q, tc and ovf match every cycle.
